// File: rtl/l1_to_wishbone.sv
// Bridges one L1 arbiter request at a time onto a Wishbone B4 master port.
// Reads may burst (size+1 beats); writes are always a single beat.
module l1_to_wishbone #(
   parameter bit BURST_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   // L1 request (arbiter -> bridge)
   input  logic [31:0] l1_req_addr,
   input  logic [31:0] l1_req_data,
   input  logic        l1_req_rnw,
   input  logic [3:0]  l1_req_be,
   input  logic [4:0]  l1_req_size,
   input  logic        l1_req_is_amo,
   input  logic [4:0]  l1_req_amo,
   input  logic        l1_req_request,
   output logic        l1_req_ack,
   // L1 response (bridge -> arbiter)
   output logic [31:0] l1_rsp_data,
   output logic        l1_rsp_data_valid,
   output logic [31:2] l1_rsp_inv_addr,
   output logic        l1_rsp_inv_valid,
   input  logic        l1_rsp_inv_ack,
   // Wishbone master
   output logic [29:0] wb_adr,
   output logic [31:0] wb_dat_w,
   output logic [3:0]  wb_sel,
   output logic        wb_cyc,
   output logic        wb_stb,
   output logic        wb_we,
   output logic [2:0]  wb_cti,
   output logic [1:0]  wb_bte,
   input  logic [31:0] wb_dat_r,
   input  logic        wb_ack,
   input  logic        wb_err,
   output logic        bus_err
);

   typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

   state_e      state_q, state_d;
   logic [29:0] addr_q;
   logic [31:0] data_q;
   logic [3:0]  be_q;
   logic [4:0]  size_q;
   logic [4:0]  beat_q, beat_d;
   logic [31:0] rdata_q;
   logic        dv_q;
   logic        berr_q;

   logic accept;
   logic busy;
   logic term;
   logic last;

   // AMO fields and invalidation handshake are not supported by this bridge.
   logic unused_inputs;
   assign unused_inputs = ^{l1_req_addr[1:0], l1_req_is_amo, l1_req_amo, l1_rsp_inv_ack};

   assign accept = l1_req_request && (state_q == StIdle);
   assign busy   = (state_q != StIdle);
   // Any ack or err closes the beat; err wins when both are high.
   assign term   = busy && (wb_ack || wb_err);
   assign last   = (state_q == StWrite) || (beat_q == size_q);

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = l1_req_rnw ? StRead : StWrite;
               beat_d  = '0;
            end
         end
         default: begin
            if (term) begin
               if (last) begin
                  state_d = StIdle;
                  beat_d  = '0;
               end else begin
                  beat_d = beat_q + 5'd1;
               end
            end
         end
      endcase
   end

   always_comb begin
      wb_adr   = '0;
      wb_dat_w = '0;
      wb_sel   = '0;
      wb_we    = 1'b0;
      wb_cti   = 3'b000;
      if (busy) begin
         wb_adr   = addr_q + {25'd0, beat_q};
         wb_we    = (state_q == StWrite);
         wb_sel   = wb_we ? be_q : 4'hF;
         wb_dat_w = wb_we ? data_q : '0;
         if (BURST_EN) begin
            wb_cti = (wb_we || last) ? 3'b111 : 3'b010;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         beat_q  <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         be_q    <= '0;
         size_q  <= '0;
         rdata_q <= '0;
         dv_q    <= 1'b0;
         berr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         if (accept) begin
            addr_q <= l1_req_addr[31:2];
            data_q <= l1_req_data;
            be_q   <= l1_req_be;
            size_q <= l1_req_size;
         end
         dv_q   <= term && (state_q == StRead);
         berr_q <= term && wb_err;
         if (term && (state_q == StRead)) begin
            rdata_q <= wb_dat_r;
         end
      end
   end

   assign l1_req_ack        = accept;
   assign l1_rsp_data       = rdata_q;
   assign l1_rsp_data_valid = dv_q;
   assign l1_rsp_inv_addr   = '0;
   assign l1_rsp_inv_valid  = 1'b0;
   assign wb_cyc            = busy;
   assign wb_stb            = busy;
   assign wb_bte            = 2'b00;
   assign bus_err           = berr_q;

endmodule

// File: tb/tb_l1_to_wishbone.sv
// Randomized bench for l1_to_wishbone: burst and classic instances share stimulus and
// are checked every cycle against a transaction-level model of the expected bus activity.
module tb_l1_to_wishbone;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [31:0] req_addr, req_data, wb_dat_r;
   logic        req_rnw, req_is_amo, req_request, inv_ack, wb_ack, wb_err;
   logic [3:0]  req_be;
   logic [4:0]  req_size, req_amo;

   logic        ack_b, dv_b, invv_b, cyc_b, stb_b, we_b, berr_b;
   logic [31:0] data_b, datw_b;
   logic [31:2] inva_b;
   logic [29:0] adr_b;
   logic [3:0]  sel_b;
   logic [2:0]  cti_b;
   logic [1:0]  bte_b;

   logic        ack_c, dv_c, invv_c, cyc_c, stb_c, we_c, berr_c;
   logic [31:0] data_c, datw_c;
   logic [31:2] inva_c;
   logic [29:0] adr_c;
   logic [3:0]  sel_c;
   logic [2:0]  cti_c;
   logic [1:0]  bte_c;

   l1_to_wishbone #(.BURST_EN(1'b1)) u_burst (
      .clk(clk), .rst(rst),
      .l1_req_addr(req_addr), .l1_req_data(req_data), .l1_req_rnw(req_rnw),
      .l1_req_be(req_be), .l1_req_size(req_size), .l1_req_is_amo(req_is_amo),
      .l1_req_amo(req_amo), .l1_req_request(req_request), .l1_req_ack(ack_b),
      .l1_rsp_data(data_b), .l1_rsp_data_valid(dv_b), .l1_rsp_inv_addr(inva_b),
      .l1_rsp_inv_valid(invv_b), .l1_rsp_inv_ack(inv_ack),
      .wb_adr(adr_b), .wb_dat_w(datw_b), .wb_sel(sel_b), .wb_cyc(cyc_b), .wb_stb(stb_b),
      .wb_we(we_b), .wb_cti(cti_b), .wb_bte(bte_b), .wb_dat_r(wb_dat_r), .wb_ack(wb_ack),
      .wb_err(wb_err), .bus_err(berr_b)
   );

   l1_to_wishbone #(.BURST_EN(1'b0)) u_classic (
      .clk(clk), .rst(rst),
      .l1_req_addr(req_addr), .l1_req_data(req_data), .l1_req_rnw(req_rnw),
      .l1_req_be(req_be), .l1_req_size(req_size), .l1_req_is_amo(req_is_amo),
      .l1_req_amo(req_amo), .l1_req_request(req_request), .l1_req_ack(ack_c),
      .l1_rsp_data(data_c), .l1_rsp_data_valid(dv_c), .l1_rsp_inv_addr(inva_c),
      .l1_rsp_inv_valid(invv_c), .l1_rsp_inv_ack(inv_ack),
      .wb_adr(adr_c), .wb_dat_w(datw_c), .wb_sel(sel_c), .wb_cyc(cyc_c), .wb_stb(stb_c),
      .wb_we(we_c), .wb_cti(cti_c), .wb_bte(bte_c), .wb_dat_r(wb_dat_r), .wb_ack(wb_ack),
      .wb_err(wb_err), .bus_err(berr_c)
   );

   int total = 0;
   int bad   = 0;

   // Model expectations for the current cycle; nxt_* become visible one cycle later.
   bit          check_en = 1'b0;
   logic        exp_ack = 1'b0, exp_cyc = 1'b0, exp_we = 1'b0, exp_chk_datw = 1'b0;
   logic        exp_dv = 1'b0, exp_berr = 1'b0, nxt_dv = 1'b0, nxt_berr = 1'b0;
   logic [29:0] exp_adr = '0;
   logic [3:0]  exp_sel = '0;
   logic [2:0]  exp_cti_b = '0;
   logic [31:0] exp_datw = '0, exp_data = '0, nxt_data = '0;

   logic [29:0] adr_log[$];
   logic [2:0]  cti_log[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s at %0t: got %h want %h", name, $time, act, want);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         chk("ack_b", 32'(ack_b), 32'(exp_ack));
         chk("ack_c", 32'(ack_c), 32'(exp_ack));
         chk("cyc_b", 32'(cyc_b), 32'(exp_cyc));
         chk("stb_b", 32'(stb_b), 32'(exp_cyc));
         chk("cyc_c", 32'(cyc_c), 32'(exp_cyc));
         chk("stb_c", 32'(stb_c), 32'(exp_cyc));
         if (exp_cyc) begin
            chk("adr_b", 32'(adr_b), 32'(exp_adr));
            chk("adr_c", 32'(adr_c), 32'(exp_adr));
            chk("we_b", 32'(we_b), 32'(exp_we));
            chk("we_c", 32'(we_c), 32'(exp_we));
            chk("sel_b", 32'(sel_b), 32'(exp_sel));
            chk("sel_c", 32'(sel_c), 32'(exp_sel));
            chk("cti_b", 32'(cti_b), 32'(exp_cti_b));
            chk("cti_c", 32'(cti_c), 32'd0);
            chk("bte_b", 32'(bte_b), 32'd0);
            chk("bte_c", 32'(bte_c), 32'd0);
            if (exp_chk_datw) begin
               chk("dat_w_b", datw_b, exp_datw);
               chk("dat_w_c", datw_c, exp_datw);
            end
         end
         chk("dv_b", 32'(dv_b), 32'(exp_dv));
         chk("dv_c", 32'(dv_c), 32'(exp_dv));
         if (exp_dv) begin
            chk("data_b", data_b, exp_data);
            chk("data_c", data_c, exp_data);
         end
         chk("bus_err_b", 32'(berr_b), 32'(exp_berr));
         chk("bus_err_c", 32'(berr_c), 32'(exp_berr));
         chk("inv_b", {inva_b, 1'b0, invv_b}, 32'd0);
         chk("inv_c", {inva_c, 1'b0, invv_c}, 32'd0);
      end
      if (cyc_b && (wb_ack || wb_err)) begin
         adr_log.push_back(adr_b);
         cti_log.push_back(cti_b);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      exp_dv   = nxt_dv;
      exp_data = nxt_data;
      exp_berr = nxt_berr;
      nxt_dv   = 1'b0;
      nxt_berr = 1'b0;
   endtask

   task automatic idle_noise();
      wb_ack   = 1'($urandom);
      wb_err   = 1'($urandom);
      wb_dat_r = $urandom;
   endtask

   task automatic set_busy(input logic [29:0] base, input int i, input logic rnw,
                           input logic last, input logic [3:0] be, input logic [31:0] d);
      exp_cyc      = 1'b1;
      exp_ack      = 1'b0;
      exp_adr      = base + 30'(i);
      exp_we       = !rnw;
      exp_sel      = rnw ? 4'hF : be;
      exp_datw     = d;
      exp_chk_datw = !rnw;
      exp_cti_b    = (!rnw || last) ? 3'b111 : 3'b010;
   endtask

   // One complete request: acceptance, every beat with optional wait states, trailing idle.
   task automatic run_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                          input logic rnw, input logic [4:0] size, input int dly,
                          input logic [31:0] errm, input int abort_after, input bit pre);
      int   nb;
      int   w;
      logic e;
      nb = rnw ? int'(size) + 1 : 1;
      if (!pre) step();
      req_request = 1'b1;
      req_addr    = a;
      req_data    = d;
      req_be      = be;
      req_rnw     = rnw;
      req_size    = size;
      req_is_amo  = 1'($urandom);
      req_amo     = 5'($urandom);
      idle_noise();
      exp_cyc     = 1'b0;
      exp_ack     = 1'b1;
      for (int i = 0; i < nb; i++) begin
         w = (dly < 0) ? int'($urandom_range(0, 2)) : dly;
         for (int k = 0; k < w; k++) begin
            step();
            set_busy(a[31:2], i, rnw, i == nb - 1, be, d);
            req_request = 1'($urandom);
            req_addr    = $urandom;
            req_rnw     = 1'($urandom);
            req_size    = 5'($urandom);
            wb_ack      = 1'b0;
            wb_err      = 1'b0;
            wb_dat_r    = $urandom;
         end
         step();
         set_busy(a[31:2], i, rnw, i == nb - 1, be, d);
         req_request = 1'b0;
         e           = errm[i];
         wb_err      = e;
         wb_ack      = e ? 1'($urandom) : 1'b1;
         wb_dat_r    = $urandom;
         if (rnw) begin
            nxt_dv   = 1'b1;
            nxt_data = wb_dat_r;
         end
         nxt_berr = e;
         if (i == abort_after) return;
      end
      step();
      req_request = 1'b0;
      exp_cyc     = 1'b0;
      exp_ack     = 1'b0;
      idle_noise();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cyc"}, {30'd0, cyc_b, cyc_c}, 32'd0);
      chk({tag, "_stb"}, {30'd0, stb_b, stb_c}, 32'd0);
      chk({tag, "_dv"}, {30'd0, dv_b, dv_c}, 32'd0);
      chk({tag, "_data"}, data_b | data_c, 32'd0);
      chk({tag, "_berr"}, {30'd0, berr_b, berr_c}, 32'd0);
      chk({tag, "_adr"}, 32'(adr_b | adr_c), 32'd0);
      chk({tag, "_dat_w"}, datw_b | datw_c, 32'd0);
      chk({tag, "_sel_we_cti_bte"}, {19'd0, sel_b, sel_c, we_b, we_c, cti_b, bte_b}, 32'd0);
   endtask

   logic [31:0] ra;
   logic [4:0]  rs;

   initial begin
      req_addr = '0; req_data = '0; req_rnw = 1'b0; req_be = '0; req_size = '0;
      req_is_amo = 1'b0; req_amo = '0; req_request = 1'b0; inv_ack = 1'b0;
      wb_dat_r = 32'hA5A5A5A5; wb_ack = 1'b1; wb_err = 1'b1;
      #2;
      chk_reset_outputs("por");
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_en = 1'b1;

      // Single read with two wait states, first request in the first cycle out of reset.
      adr_log.delete(); cti_log.delete();
      run_txn(32'h0000_1000, $urandom, 4'hF, 1'b1, 5'd0, 2, 32'd0, -1, 1'b1);
      chk("single_beats", 32'(adr_log.size()), 32'd1);
      chk("single_adr", 32'(adr_log[0]), 32'h400);
      chk("single_cti", 32'(cti_log[0]), 32'd7);

      // Four-beat burst, slave acks every cycle.
      adr_log.delete(); cti_log.delete();
      run_txn(32'h0000_0010, $urandom, 4'hF, 1'b1, 5'd3, 0, 32'd0, -1, 1'b0);
      chk("burst_beats", 32'(adr_log.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk("burst_adr", 32'(adr_log[i]), 32'(4 + i));
         chk("burst_cti", 32'(cti_log[i]), (i == 3) ? 32'd7 : 32'd2);
      end

      // Write ignores size.
      adr_log.delete(); cti_log.delete();
      run_txn(32'h0000_0020, 32'hDEAD_BEEF, 4'b0011, 1'b0, 5'd5, 1, 32'd0, -1, 1'b0);
      chk("write_beats", 32'(adr_log.size()), 32'd1);
      chk("write_adr", 32'(adr_log[0]), 32'h8);

      // Address wrap with an error on beat 0.
      adr_log.delete(); cti_log.delete();
      run_txn(32'hFFFF_FFFC, $urandom, 4'hF, 1'b1, 5'd1, 0, 32'd1, -1, 1'b0);
      chk("wrap_beats", 32'(adr_log.size()), 32'd2);
      chk("wrap_adr0", 32'(adr_log[0]), 32'h3FFF_FFFF);
      chk("wrap_adr1", 32'(adr_log[1]), 32'd0);

      // Three beats with backpressure; classic instance must keep cti at 000.
      run_txn(32'h0000_0040, $urandom, 4'hF, 1'b1, 5'd2, 1, 32'd0, -1, 1'b0);

      // Reset mid-burst after beat 2.
      run_txn(32'h0000_0100, $urandom, 4'hF, 1'b1, 5'd7, 0, 32'd0, 2, 1'b0);
      @(negedge clk);
      #1;
      check_en = 1'b0;
      rst = 1'b1;
      #1;
      chk_reset_outputs("rst_async");
      @(posedge clk);
      #1;
      chk_reset_outputs("rst_hold");
      rst = 1'b0;
      nxt_dv = 1'b0; nxt_berr = 1'b0; exp_dv = 1'b0; exp_berr = 1'b0;
      check_en = 1'b1;
      run_txn(32'h0000_0200, $urandom, 4'hF, 1'b1, 5'd1, -1, 32'd0, -1, 1'b1);

      for (int n = 0; n < 40; n++) begin
         ra = $urandom;
         if (n % 5 == 0) ra[31:6] = '1;
         rs = (n % 10 == 3) ? 5'd31 : 5'($urandom_range(0, 7));
         run_txn(ra, $urandom, 4'($urandom), 1'($urandom), rs, -1,
                 $urandom & $urandom & $urandom, -1, 1'b0);
      end

      @(negedge clk);
      #1;
      check_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/l1_to_wishbone.md
L1_TO_WISHBONE -- requirements
Module: l1_to_wishbone

Interface
REQ-001 The block SHALL have parameter BURST_EN, default 1: 1 = registered-feedback incrementing bursts (cti 010/111), 0 = classic cycles (cti 000).
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have port l1_request, l1_arbiter_request_interface.slave: addr[31:0], data[31:0], rnw, be[3:0], size[4:0], is_amo, amo[4:0], request in; ack out.
REQ-005 The block SHALL have port l1_response, l1_arbiter_return_interface.slave: data[31:0], data_valid, inv_addr[31:2], inv_valid out; inv_ack in.
REQ-006 The block SHALL have port wishbone, wishbone_interface.master: adr[29:0], dat_w[31:0], sel[3:0], cyc, stb, we, cti[2:0], bte[1:0] out; dat_r[31:0], ack, err in.
REQ-007 The block SHALL have port bus_err, output, 1, one-cycle pulse when a Wishbone beat terminates with err.

Function
REQ-008 The block SHALL implement a three-state FSM: IDLE, READ, WRITE.
REQ-009 The block SHALL drive l1_request.ack = request AND state==IDLE (combinational); a request is accepted on the cycle where request and ack are both high.
REQ-010 On acceptance, the block SHALL latch addr[31:2], data, be, rnw and size; go to READ if rnw=1, else WRITE.
REQ-011 The block SHALL ignore is_amo and amo; the access executes as a plain read or write per rnw.
REQ-012 In READ/WRITE, the block SHALL assert cyc=stb=1 from the cycle after acceptance until the cycle after the final beat's ack or err; both SHALL be 0 in IDLE.
REQ-013 The block SHALL drive adr = latched addr[31:2] + beat_count, modulo 2^30 (wrap from 30'h3FFFFFFF to 0).
REQ-014 READ: beat_count (5 bits) SHALL start at 0, increment on each ack or err, and the transfer SHALL end on the beat with beat_count == latched size (size+1 beats total, 1..32).
REQ-015 READ: the block SHALL drive we=0 and sel=4'hF.
REQ-016 READ with BURST_EN=1: cti SHALL be 010 on non-final beats and 111 on the final beat; bte SHALL be 00.
REQ-017 With BURST_EN=0: cti SHALL be 000 and bte 00 on all beats.
REQ-018 READ: for every beat ending in ack or err, the block SHALL drive l1_response.data = dat_r and data_valid=1 in the following cycle, for exactly one cycle per beat.
REQ-019 WRITE: the block SHALL perform exactly one beat regardless of size, with we=1, sel=latched be, dat_w=latched data, and cti=111 (BURST_EN=1) or 000.
REQ-020 WRITE: the block SHALL produce no data_valid.
REQ-021 On the final beat's ack or err, the block SHALL return to IDLE; ack in IDLE is therefore at least one cycle after that beat (no back-to-back acceptance).
REQ-022 bus_err SHALL pulse in the cycle after any beat terminating with err; on a read it SHALL coincide with that beat's data_valid.
REQ-023 An err beat SHALL count as a completed beat; the burst SHALL continue to its final beat.
REQ-024 If ack and err are both high, the block SHALL treat the beat as err.
REQ-025 The block SHALL tie inv_valid=0 and inv_addr=0 and ignore inv_ack.
REQ-026 Wishbone ack/err outside READ/WRITE SHALL be ignored.

Reset
REQ-027 While rst=1, the block SHALL hold state=IDLE, beat_count=0, cyc=stb=we=0, cti=000, bte=00, sel=0, adr=0, dat_w=0, data_valid=0, data=0, and bus_err=0.
REQ-028 Reset assertion mid-transfer SHALL drop cyc/stb immediately (asynchronously) and discard any pending data_valid.
REQ-029 After reset, the first request SHALL be ackable in the first cycle after rst deasserts.

Verification
REQ-030 Single read: addr=0x00001000, rnw=1, size=0; slave acks 2 cycles after stb -> adr=0x400, cti=111, sel=F, one data_valid carrying dat_r, then IDLE.
REQ-031 Burst read: addr=0x00000010, size=3, BURST_EN=1, slave acks every cycle -> adr 4,5,6,7; cti 010,010,010,111; 4 consecutive data_valid pulses.
REQ-032 Write: addr=0x20, data=0xDEADBEEF, be=4'b0011, size=5 -> one beat: adr=0x8, we=1, sel=0011, dat_w=DEADBEEF; no data_valid.
REQ-033 Wrap and error: addr=0xFFFFFFFC, size=1; err on beat 0 -> adr 3FFFFFFF then 0; bus_err pulse with first data_valid; second beat still performed.
REQ-034 Reset mid-burst: size=7, rst asserted after beat 2 -> cyc/stb low immediately, no further data_valid, ack available the cycle after rst release.
REQ-035 Classic mode: BURST_EN=0, size=2 -> cti=000 on all 3 beats; each of request, ack, and backpressure (slave delays ack) exercised.
